// File: rtl/coproc_pkg.sv
// coproc_pkg: types and frame-size defaults shared by the window generator
// and the processing element.
//   pixel_t  : one RGB444 pixel
//   window_t : 3x3 neighbourhood, indexed [row][col] with row 0 at the top
//   ctr_w()  : width of a counter that must hold 0..n-1
package coproc_pkg;

  localparam int IMG_W_DEF = 160;
  localparam int IMG_H_DEF = 120;
  localparam int PIX_W_DEF = 12;

  typedef logic [PIX_W_DEF-1:0] pixel_t;
  typedef pixel_t window_t [3][3];

  function automatic int ctr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_gen_if.sv
// window_gen_if: pixel stream in, 3x3 window stream out.
//   in_valid/in_ready/in_pix/in_last : raster-order pixel handshake
//   out_valid/out_ready              : window handshake
//   out_w00..out_w22                 : window pixels, wRC (row R, column C)
//   out_last                         : window centred on the last interior pixel
// Modports: master = upstream/downstream side, slave = window_gen.
interface window_gen_if
  import coproc_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_w00, out_w01, out_w02;
  logic [PIX_W-1:0] out_w10, out_w11, out_w12;
  logic [PIX_W-1:0] out_w20, out_w21, out_w22;
  logic             out_last;

  modport master (
    output in_valid, in_pix, in_last, out_ready,
    input  in_ready, out_valid, out_last,
    input  out_w00, out_w01, out_w02,
    input  out_w10, out_w11, out_w12,
    input  out_w20, out_w21, out_w22
  );

  modport slave (
    input  in_valid, in_pix, in_last, out_ready,
    output in_ready, out_valid, out_last,
    output out_w00, out_w01, out_w02,
    output out_w10, out_w11, out_w12,
    output out_w20, out_w21, out_w22
  );

endinterface

// File: rtl/window_gen_line_buffer.sv
// line_buffer: one image row of storage.
//   clk   : rising-edge clock
//   we    : write enable
//   addr  : column address, shared by read and write
//   wdata : pixel written at addr
//   rdata : combinational read of addr (old contents during a write cycle)
// Contents are not reset; they are always rewritten before being used.
module line_buffer #(
  parameter int DEPTH = 160,
  parameter int PIX_W = 12,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/window_gen.sv
// window_gen: streaming 3x3 window generator. Accepts one raster-order pixel
// per handshake, keeps the two previous rows in line buffers and emits every
// interior 3x3 neighbourhood ((W-2) x (H-2) windows per frame).
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   clr       : synchronous soft clear (counters, window, out_valid, frame_err)
//   bus       : window_gen_if slave (pixel in, window out)
//   frame_err : sticky in_last misalignment flag (WINDOW_GEN_FRAME_CHK_EN only)
// Optional feature macro: WINDOW_GEN_FRAME_CHK_EN enables in_last checking
// and early-in_last counter resync.
module window_gen
  import coproc_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  window_gen_if.slave bus
`ifdef WINDOW_GEN_FRAME_CHK_EN
  ,
  output logic        frame_err
`endif
);

  localparam int CW = ctr_w(IMG_W);
  localparam int RW = ctr_w(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             accept;
  logic             wr_en;
  logic             at_end;
  logic             emit;
  logic             resync;
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;

  // win[c][r]: column 0 is the oldest (leftmost), row 0 the oldest (top)
  logic [PIX_W-1:0] win [3][3];

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  // A pixel arriving together with clr is dropped, buffers included.
  assign wr_en        = accept && !clr;
  assign at_end       = (row == ROW_MAX) && (col == COL_MAX);
  assign emit         = (row >= RW'(2)) && (col >= CW'(2));

`ifdef WINDOW_GEN_FRAME_CHK_EN
  assign resync = bus.in_last && !at_end;
`else
  assign resync = 1'b0;
`endif

  // lb0 holds row r-1, lb1 row r-2; lb1 takes lb0's old value in the same
  // cycle, so the read-before-write of both gives the full column.
  line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .AW(CW)) u_lb0 (
    .clk   (clk),
    .we    (wr_en),
    .addr  (col),
    .wdata (bus.in_pix),
    .rdata (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .AW(CW)) u_lb1 (
    .clk   (clk),
    .we    (wr_en),
    .addr  (col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // Raster position of the pixel currently offered
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (resync || at_end) begin
        col <= '0;
        row <= '0;
      end else if (col == COL_MAX) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Window shift register and one-deep output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          win[c][r] <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_w00   <= '0;
      bus.out_w01   <= '0;
      bus.out_w02   <= '0;
      bus.out_w10   <= '0;
      bus.out_w11   <= '0;
      bus.out_w12   <= '0;
      bus.out_w20   <= '0;
      bus.out_w21   <= '0;
      bus.out_w22   <= '0;
    end else if (clr) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          win[c][r] <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (accept) begin
        win[0]    <= win[1];
        win[1]    <= win[2];
        win[2][0] <= lb1_rd;
        win[2][1] <= lb0_rd;
        win[2][2] <= bus.in_pix;
      end
      // Outputs are taken from the post-shift window, i.e. the new column
      // comes straight from the buffers and in_pix.
      if (accept && emit) begin
        bus.out_w00   <= win[1][0];
        bus.out_w01   <= win[2][0];
        bus.out_w02   <= lb1_rd;
        bus.out_w10   <= win[1][1];
        bus.out_w11   <= win[2][1];
        bus.out_w12   <= lb0_rd;
        bus.out_w20   <= win[1][2];
        bus.out_w21   <= win[2][2];
        bus.out_w22   <= bus.in_pix;
        bus.out_last  <= at_end;
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

`ifdef WINDOW_GEN_FRAME_CHK_EN
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      frame_err <= 1'b0;
    end else if (accept && (bus.in_last != at_end)) begin
      frame_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_window_gen.sv
module tb_window_gen;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  always #5 clk = ~clk;

  window_gen_if #(.PIX_W(PW)) bus ();

`ifdef WINDOW_GEN_FRAME_CHK_EN
  logic frame_err;
  window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus), .frame_err(frame_err));
`else
  window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus));
`endif

  typedef struct packed {
    logic                 last;
    logic [8:0][PW-1:0]   p;     // index 3*row + col
  } win_s;

  win_s          exp_q[$];
  win_s          obs_q[$];
  logic [PW-1:0] img [H][W];
  int            mr = 0, mc = 0;
  logic          exp_err = 1'b0;
  int            n_vec = 0, n_fail = 0;
  int            rmode = 0, stall_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic win_s dut_win();
    win_s w;
    w.p[0] = bus.out_w00; w.p[1] = bus.out_w01; w.p[2] = bus.out_w02;
    w.p[3] = bus.out_w10; w.p[4] = bus.out_w11; w.p[5] = bus.out_w12;
    w.p[6] = bus.out_w20; w.p[7] = bus.out_w21; w.p[8] = bus.out_w22;
    w.last = bus.out_last;
    return w;
  endfunction

  // Reference: store the frame as an image and cut the 3x3 patch ending at
  // the accepted pixel whenever a full interior neighbourhood exists.
  task automatic model_accept(input logic [PW-1:0] pix, input logic last);
    win_s w;
    logic at_end;
    img[mr][mc] = pix;
    at_end = (mr == H-1) && (mc == W-1);
    if (mr >= 2 && mc >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w.p[3*i+j] = img[mr-2+i][mc-2+j];
      w.last = at_end;
      exp_q.push_back(w);
    end
`ifdef WINDOW_GEN_FRAME_CHK_EN
    if (last != at_end) exp_err = 1'b1;
    if (last && !at_end) begin
      mr = 0; mc = 0;
      return;
    end
`endif
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) mr = 0;
    end
  endtask

  // Compare process
  always @(negedge clk) begin
    if (rst_n) begin
      win_s d, e;
      check("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
      check("out_valid", bus.out_valid, exp_q.size() != 0);
`ifdef WINDOW_GEN_FRAME_CHK_EN
      check("frame_err", frame_err, exp_err);
`endif
      if (bus.out_valid && exp_q.size() != 0) begin
        d = dut_win();
        e = exp_q[0];
        for (int i = 0; i < 9; i++)
          check($sformatf("w%0d%0d", i/3, i%3), d.p[i], e.p[i]);
        check("out_last", d.last, e.last);
      end
      if (bus.out_valid && bus.out_ready) begin
        obs_q.push_back(dut_win());
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (clr) begin
        exp_q.delete();
        mr = 0; mc = 0;
        exp_err = 1'b0;
      end else if (bus.in_valid && bus.in_ready) begin
        model_accept(bus.in_pix, bus.in_last);
      end
    end
  end

  // Downstream ready generator
  always @(posedge clk) begin
    #1;
    case (rmode)
      1: bus.out_ready = 1'($urandom_range(1));
      2: if (bus.out_valid && obs_q.size() == 1 && stall_left > 0) begin
           bus.out_ready = 1'b0;
           stall_left--;
         end else begin
           bus.out_ready = 1'b1;
         end
      3: bus.out_ready = 1'b0;
      default: bus.out_ready = 1'b1;
    endcase
  end

  task automatic send_pix(input logic [PW-1:0] p, input logic last, input bit bubble);
    int  guard;
    logic ok;
    while (bubble && $urandom_range(99) < 50) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_pix   = p;
    bus.in_last  = last;
    guard = 0;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!ok && guard < 1000);
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input bit rnd, input bit bubble);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pix(rnd ? PW'($urandom) : PW'(r*W + c), (r == H-1) && (c == W-1), bubble);
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 500) check("drain_timeout", 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pix    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_last", bus.out_last, 0);
    check("rst_w00", bus.out_w00, 0);
    check("rst_w11", bus.out_w11, 0);
    check("rst_w22", bus.out_w22, 0);
`ifdef WINDOW_GEN_FRAME_CHK_EN
    check("rst_frame_err", frame_err, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Continuous frame
    obs_q.delete();
    rmode = 0;
    send_frame(0, 0);
    drain();
    check("t1_count", obs_q.size(), 4);
    check("t1_first_w00", obs_q[0].p[0], 0);
    check("t1_first_w11", obs_q[0].p[4], 5);
    check("t1_first_w22", obs_q[0].p[8], 10);
    check("t1_first_last", obs_q[0].last, 0);
    check("t1_last_w00", obs_q[3].p[0], 5);
    check("t1_last_w22", obs_q[3].p[8], 15);
    check("t1_last_last", obs_q[3].last, 1);

    // Downstream stall on the second window
    obs_q.delete();
    rmode = 2; stall_left = 5;
    send_frame(0, 0);
    drain();
    check("t2_stalled", stall_left, 0);
    check("t2_count", obs_q.size(), 4);
    check("t2_w2_center", obs_q[1].p[4], 6);
    check("t2_w3_center", obs_q[2].p[4], 9);

    // Random bubbles upstream and downstream
    obs_q.delete();
    rmode = 1;
    send_frame(0, 1);
    rmode = 0;
    drain();
    check("t3_count", obs_q.size(), 4);
    check("t3_c0", obs_q[0].p[4], 5);
    check("t3_c1", obs_q[1].p[4], 6);
    check("t3_c2", obs_q[2].p[4], 9);
    check("t3_c3", obs_q[3].p[4], 10);

    // Back-to-back frames
    obs_q.delete();
    send_frame(0, 0);
    send_frame(0, 0);
    drain();
    check("t4_count", obs_q.size(), 8);
    check("t4_f2_w00", obs_q[4].p[0], 0);
    check("t4_f2_w11", obs_q[4].p[4], 5);
    check("t4_f2_w22", obs_q[4].p[8], 10);

    // Back-to-back random frames with random handshakes
    obs_q.delete();
    rmode = 1;
    repeat (3) send_frame(1, 1);
    rmode = 0;
    drain();
    check("t4r_count", obs_q.size(), 12);

    // clr after 7 accepts with a pixel in flight
    obs_q.delete();
    for (int i = 0; i < 7; i++) send_pix(PW'(i), 1'b0, 0);
    clr = 1'b1; bus.in_valid = 1'b1; bus.in_pix = PW'(7);
    @(posedge clk); #1;
    clr = 1'b0; bus.in_valid = 1'b0;
    check("t5_valid_after_clr", bus.out_valid, 0);
    // clr while a stalled window is pending
    rmode = 3;
    for (int i = 0; i < 11; i++) send_pix(PW'(100 + i), 1'b0, 0);
    check("t5_pending", bus.out_valid, 1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("t5_valid_after_clr2", bus.out_valid, 0);
    rmode = 0;
    @(posedge clk); #1;
    obs_q.delete();
    send_frame(0, 0);
    drain();
    check("t5_count", obs_q.size(), 4);
    check("t5_first_w00", obs_q[0].p[0], 0);
    check("t5_last_w22", obs_q[3].p[8], 15);

`ifdef WINDOW_GEN_FRAME_CHK_EN
    // Early in_last on pixel 9
    obs_q.delete();
    for (int i = 0; i < 10; i++) send_pix(PW'(200 + i), i == 9, 0);
    @(posedge clk); #1;
    check("t6_err_set", frame_err, 1);
    send_frame(0, 0);
    drain();
    check("t6_count", obs_q.size(), 4);
    check("t6_first_w11", obs_q[0].p[4], 5);
    check("t6_err_sticky", frame_err, 1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("t6_err_clr", frame_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/window_gen.md
# window_gen

Streaming 3x3 window generator for the image coprocessor: accepts one raster-order pixel per handshake, buffers the two previous image rows, and presents a complete 3x3 neighbourhood to the processing element's convolution units. It sits directly upstream of the per-channel conv units. Each 12-bit RGB444 pixel is split into three 4-bit channel slices by the processing element. Only interior windows are produced: a W x H frame yields (W-2) x (H-2) windows.

## Interface
- IMG_W, 160: frame width in pixels, minimum 3.
- IMG_H, 120: frame height in pixels, minimum 3.
- PIX_W, 12: pixel width in bits (RGB444).
- clk  input  1  single clock; all logic is rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- clr  input  1  synchronous soft clear at frame start. Clears counters, window and out_valid, but not line buffer RAM.
- in_valid  input  1  upstream pixel valid.
- in_ready  output  1  block can accept a pixel this cycle.
- in_pix  input  PIX_W  pixel data, raster order.
- in_last  input  1  marks the final pixel of a frame.
- out_valid  output  1  window valid.
- out_ready  input  1  downstream accepts the window.
- out_w00 … out_w22  output  PIX_W each  nine window pixels. wRC: R is the row (0 = top, oldest), C is the column (0 = left, oldest). w11 is the centre.
- out_last  output  1  set with the window centred at (IMG_H-2, IMG_W-2).
- frame_err  output  1  sticky frame-alignment error. Present only with the configuration macro.

## Operation
- Accept: in_valid && in_ready. in_ready = !out_valid || out_ready. The output register is one-deep.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1, width $clog2 of the maximum.
  - col advances on every accept.
  - At col = IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0.
- Line buffers: two arrays of IMG_W x PIX_W, combinational read, write on accept, read-before-write. On accepting pixel (r,c):
  - lb1[c] <= lb0[c]
  - lb0[c] <= in_pix
  - Pre-update contents: lb1[c] holds row r-2 and lb0[c] holds row r-1.
- Window: three column registers shift left on every accept. The new right column is {lb1[c], lb0[c], in_pix}, top to bottom.
- Emit: an accept at r>=2, c>=2 loads out_w* from the shifted window and sets out_valid. That window is centred at (r-1, c-1).
  - Any other accept leaves out_valid as follows: cleared if out_ready, else held.
  - Sustained out_valid with out_ready low holds every out_* stable.
- out_last is set when (r,c) = (IMG_H-1, IMG_W-1).
- Simultaneous output handshake and new emitting accept: the new window loads and out_valid stays 1.
- clr: takes priority over everything. Any in-flight pixel is dropped.
  - Next cycle: out_valid = 0, row = col = 0, window = 0.
- Reset (rst_n low at a clock edge): out_valid = 0, out_last = 0, all out_w* = 0, counters = 0, frame_err = 0. in_ready therefore reads 1 after reset. Line buffer contents are undefined; they are never emitted before being rewritten.
- Back-to-back frames need no gap: rows 0 and 1 of the new frame refill the buffers before any emit.

## Timing
- Latency: out_valid rises on the cycle after the accept of pixel (r,c) that completes the window.
- Throughput: one pixel per cycle while out_ready is high.
- The first window appears after 2*IMG_W+3 accepts.
- No combinational path from in_valid to out_*. in_ready depends combinationally on out_ready.

## Configuration
- WINDOW_GEN_FRAME_CHK_EN defined:
  - frame_err port exists.
  - On an accept, frame_err is set if in_last=1 at any position other than (IMG_H-1, IMG_W-1), or if in_last=0 at that position.
  - If in_last=1 is accepted early, counters resync to (0,0) after that pixel.
  - frame_err stays set until rst_n or clr.
- Not defined: frame_err port is absent, in_last is ignored, and counters wrap purely by count.

## Structure
- coproc_pkg holds:
  - pixel_t (logic [PIX_W-1:0])
  - window_t (3x3 array of pixel_t)
  - IMG_W/IMG_H defaults shared with the processing element
- One sub-module, line_buffer: an IMG_W-deep array with combinational read and synchronous write. It is instantiated twice.

## Test plan
- IMG_W=IMG_H=4, in_pix = 4r+c, streamed continuously with out_ready=1 -> exactly 4 windows.
  - First window: w00=0, w11=5, w22=10.
  - Last window: w00=5, w22=15, with out_last=1.
- Same stream with out_ready low for 5 cycles on window 2 -> in_ready=0, outputs held stable, no window lost or duplicated.
- Random in_valid bubbles (50%) -> window sequence identical to the continuous case.
- Two 4x4 frames back-to-back -> second frame's first window is w00=0, w11=5, w22=10 from the new data (no old-frame pixels); exactly 8 windows total.
- clr after 7 accepts -> out_valid=0 next cycle; then a full 4x4 frame gives 4 correct windows.
- With WINDOW_GEN_FRAME_CHK_EN: in_last on pixel 9 -> frame_err=1; the next accepted pixel is treated as (0,0); frame_err stays 1 until clr.
